// File: rtl/score_scan_display.sv
//============================================================================
// Module   : score_scan_display
// Purpose  : Two-player Pong scoreboard. Keeps a BCD score per player,
//            latches the winner and multiplexes every score digit onto one
//            shared seven-segment bus with leading-zero blanking.
// Options  : WIN_BLINK_EN - when defined, the winner's digits blink while
//            the game is over.
// Revision : 1.0 - initial release
//============================================================================
`default_nettype none

module score_scan_display #(
  parameter int DIGITS_PER_PLAYER = 2,
  parameter int SCAN_BITS         = 17,
  parameter int WIN_SCORE         = 11,
  parameter bit ACTIVE_LOW        = 1'b1,
  parameter int BLINK_BITS        = 24
) (
  input  logic                             clk25,
  input  logic                             reset,
  input  logic                             point_p1,
  input  logic                             point_p2,
  input  logic                             clear,
  output logic [7:0]                       segments,
  output logic [2*DIGITS_PER_PLAYER-1:0]   digitselect,
  output logic [1:0]                       winner,
  output logic                             game_over
);

  localparam int DPP = DIGITS_PER_PLAYER;
  localparam int ND  = 2 * DPP;
  localparam int SW  = 4 * DPP;
  localparam int IW  = (ND > 1) ? $clog2(ND) : 1;

  localparam logic [IW-1:0] LAST_IDX = IW'(ND - 1);
  localparam logic [IW-1:0] DPP_IDX  = IW'(DPP);
  localparam bit            WIN_EN   = (WIN_SCORE != 0);

  // Convert a decimal constant into packed BCD digits (ones digit lowest).
  function automatic logic [SW-1:0] to_bcd(input int val);
    int            v;
    logic [SW-1:0] r;
    v = val;
    r = '0;
    for (int k = 0; k < DPP; k++) begin
      r[4*k +: 4] = 4'(v % 10);
      v = v / 10;
    end
    return r;
  endfunction

  localparam logic [SW-1:0] WIN_BCD = to_bcd(WIN_SCORE);

  // The winning score must fit in the digits available.
  if ((WIN_SCORE < 0) || (WIN_SCORE > (10**DPP) - 1)) begin : g_bad_win_score
    $error("score_scan_display: WIN_SCORE does not fit in DIGITS_PER_PLAYER digits");
  end

  // Ripple-carry decimal increment; all nines wraps to all zeros.
  function automatic logic [SW-1:0] bcd_inc(input logic [SW-1:0] v);
    logic [SW-1:0] r;
    logic          carry;
    r     = v;
    carry = 1'b1;
    for (int k = 0; k < DPP; k++) begin
      if (carry) begin
        if (v[4*k +: 4] >= 4'd9) begin
          r[4*k +: 4] = 4'd0;
        end else begin
          r[4*k +: 4] = v[4*k +: 4] + 4'd1;
          carry       = 1'b0;
        end
      end
    end
    return r;
  endfunction

  // Active-high {a,b,c,d,e,f,g,dp} pattern with dp clear.
  function automatic logic [7:0] seg7(input logic [3:0] d);
    case (d)
      4'd0:    seg7 = 8'hFC;
      4'd1:    seg7 = 8'h60;
      4'd2:    seg7 = 8'hDA;
      4'd3:    seg7 = 8'hF2;
      4'd4:    seg7 = 8'h66;
      4'd5:    seg7 = 8'hB6;
      4'd6:    seg7 = 8'hBE;
      4'd7:    seg7 = 8'hE0;
      4'd8:    seg7 = 8'hFE;
      4'd9:    seg7 = 8'hF6;
      default: seg7 = 8'h8E;
    endcase
  endfunction

  logic [SW-1:0]        p1_q, p1_d, p2_q, p2_d;
  logic [1:0]           winner_q, winner_d;
  logic                 game_over_q, game_over_d;
  logic [SCAN_BITS-1:0] dwell_q, dwell_d;
  logic [IW-1:0]        idx_q, idx_d;
  logic                 vld_q, vld_d;
  logic [7:0]           segments_q, segments_d;
  logic [ND-1:0]        digitselect_q, digitselect_d;
  logic                 hide;

  // Scores and winner: clear beats points, points frozen once the game is over.
  always_comb begin
    p1_d     = p1_q;
    p2_d     = p2_q;
    winner_d = winner_q;
    if (clear) begin
      p1_d     = '0;
      p2_d     = '0;
      winner_d = 2'b00;
    end else begin
      if (!game_over_q) begin
        if (point_p1) p1_d = bcd_inc(p1_q);
        if (point_p2) p2_d = bcd_inc(p2_q);
      end
      // Winner is taken from the registered score, so it trails the point by one edge.
      if (winner_q == 2'b00) begin
        winner_d = {WIN_EN && (p2_q == WIN_BCD), WIN_EN && (p1_q == WIN_BCD)};
      end
    end
    game_over_d = (winner_d != 2'b00);
  end

  // Dwell counter and scan index; the first terminal count only validates index 0.
  always_comb begin
    dwell_d = dwell_q + 1'b1;
    idx_d   = idx_q;
    vld_d   = vld_q;
    if (&dwell_q) begin
      if (!vld_q) begin
        vld_d = 1'b1;
      end else begin
        idx_d = (idx_q == LAST_IDX) ? '0 : idx_q + 1'b1;
      end
    end
  end

`ifdef WIN_BLINK_EN
  logic [BLINK_BITS-1:0] blink_cnt_q, blink_cnt_d;
  logic                  blink_off_q, blink_off_d;

  // Blink phase generator, parked in the lit phase outside of game over.
  always_comb begin
    blink_cnt_d = '0;
    blink_off_d = 1'b0;
    if (game_over_q) begin
      blink_cnt_d = blink_cnt_q + 1'b1;
      blink_off_d = blink_off_q ^ (&blink_cnt_q);
    end
  end

  // Hide the digits of whichever player(s) won during the off phase.
  always_comb begin
    hide = blink_off_q && ((idx_q >= DPP_IDX) ? winner_q[1] : winner_q[0]);
  end
`else
  // Final scores are shown steadily.
  always_comb begin
    hide = 1'b0;
  end
`endif

  logic [SW-1:0] sel_score;
  logic [IW-1:0] dig_k;
  logic [3:0]    digit;
  logic          upper_zero;
  logic [7:0]    seg_hi;
  logic [ND-1:0] dsel_hi;

  // Digit selection, blanking and encoding for the current scan index.
  always_comb begin
    sel_score  = (idx_q >= DPP_IDX) ? p2_q : p1_q;
    dig_k      = (idx_q >= DPP_IDX) ? (idx_q - DPP_IDX) : idx_q;
    digit      = 4'd0;
    upper_zero = 1'b1;
    for (int j = 0; j < DPP; j++) begin
      if (IW'(j) == dig_k) digit = sel_score[4*j +: 4];
      if ((IW'(j) >= dig_k) && (sel_score[4*j +: 4] != 4'd0)) upper_zero = 1'b0;
    end
    seg_hi  = 8'h00;
    dsel_hi = '0;
    if (vld_q) begin
      dsel_hi = ND'(1) << idx_q;
      if (!hide && !((dig_k != '0) && upper_zero)) begin
        seg_hi = seg7(digit) | {7'b0, (idx_q == DPP_IDX)};
      end
    end
    segments_d    = seg_hi ^ {8{ACTIVE_LOW}};
    digitselect_d = dsel_hi ^ {ND{ACTIVE_LOW}};
  end

  // State and output registers.
  always_ff @(posedge clk25) begin
    if (!reset) begin
      p1_q          <= '0;
      p2_q          <= '0;
      winner_q      <= 2'b00;
      game_over_q   <= 1'b0;
      dwell_q       <= '0;
      idx_q         <= '0;
      vld_q         <= 1'b0;
      segments_q    <= {8{ACTIVE_LOW}};
      digitselect_q <= {ND{ACTIVE_LOW}};
`ifdef WIN_BLINK_EN
      blink_cnt_q   <= '0;
      blink_off_q   <= 1'b0;
`endif
    end else begin
      p1_q          <= p1_d;
      p2_q          <= p2_d;
      winner_q      <= winner_d;
      game_over_q   <= game_over_d;
      dwell_q       <= dwell_d;
      idx_q         <= idx_d;
      vld_q         <= vld_d;
      segments_q    <= segments_d;
      digitselect_q <= digitselect_d;
`ifdef WIN_BLINK_EN
      blink_cnt_q   <= blink_cnt_d;
      blink_off_q   <= blink_off_d;
`endif
    end
  end

  assign segments    = segments_q;
  assign digitselect = digitselect_q;
  assign winner      = winner_q;
  assign game_over   = game_over_q;

endmodule

`default_nettype wire

// File: tb/tb_score_scan_display.sv
//============================================================================
// Module   : tb_score_scan_display
// Purpose  : Directed bench for score_scan_display (SCAN_BITS=2, BLINK_BITS=3)
//            plus a second instance built with WIN_SCORE=0 for wrap-around.
// Revision : 1.0 - initial release
//============================================================================
`default_nettype none
`timescale 1ns/1ps

module tb_score_scan_display;

`ifdef WIN_BLINK_EN
  localparam bit BLINK_ON = 1'b1;
`else
  localparam bit BLINK_ON = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst_n, p1, p2, clr;
  logic [7:0] seg;
  logic [3:0] dsel;
  logic [1:0] win;
  logic       go;

  logic       rst_w, p1_w, p2_w, clr_w;
  logic [7:0] seg_w;
  logic [3:0] dsel_w;
  logic [1:0] win_w;
  logic       go_w;

  logic       use_w;
  logic [7:0] mseg;
  logic [3:0] mdsel;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  int go_cyc = 0;
  bit go_seen = 1'b0;

  always #5 clk = ~clk;

  score_scan_display #(
    .DIGITS_PER_PLAYER(2), .SCAN_BITS(2), .WIN_SCORE(11),
    .ACTIVE_LOW(1'b1), .BLINK_BITS(3)
  ) dut (
    .clk25(clk), .reset(rst_n), .point_p1(p1), .point_p2(p2), .clear(clr),
    .segments(seg), .digitselect(dsel), .winner(win), .game_over(go)
  );

  score_scan_display #(
    .DIGITS_PER_PLAYER(2), .SCAN_BITS(2), .WIN_SCORE(0),
    .ACTIVE_LOW(1'b1), .BLINK_BITS(3)
  ) dut_w (
    .clk25(clk), .reset(rst_w), .point_p1(p1_w), .point_p2(p2_w), .clear(clr_w),
    .segments(seg_w), .digitselect(dsel_w), .winner(win_w), .game_over(go_w)
  );

  // Display observation point: either the main or the wrap-around instance.
  always_comb begin
    mseg  = use_w ? seg_w  : seg;
    mdsel = use_w ? dsel_w : dsel;
  end

  typedef struct {
    logic       pp1;
    logic       pp2;
    logic       clr;
    int         s1;
    int         s2;
    logic [1:0] win;
    logic       go;
    bit         disp;
  } vec_t;

  vec_t tbl[$];

  function automatic void add(logic a, logic b, logic c, int s1, int s2,
                              logic [1:0] w, logic g, bit d);
    vec_t v;
    v.pp1 = a; v.pp2 = b; v.clr = c; v.s1 = s1; v.s2 = s2;
    v.win = w; v.go = g; v.disp = d;
    tbl.push_back(v);
  endfunction

  task automatic check(string name, logic [31:0] act, logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, req);
    end
  endtask

  // One clock: sample point is 1 ns after the rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
    if (!go) go_seen = 1'b0;
    else if (!go_seen) begin
      go_seen = 1'b1;
      go_cyc  = cyc;
    end
  endtask

  function automatic logic [7:0] enc(int d);
    case (d)
      0: enc = 8'hFC; 1: enc = 8'h60; 2: enc = 8'hDA; 3: enc = 8'hF2;
      4: enc = 8'h66; 5: enc = 8'hB6; 6: enc = 8'hBE; 7: enc = 8'hE0;
      8: enc = 8'hFE; 9: enc = 8'hF6; default: enc = 8'h8E;
    endcase
  endfunction

  // Expected active-low segments for scan index idx.
  function automatic logic [7:0] want_seg(int idx, int s1, int s2, logic [1:0] w);
    int         s, k, d, n, pl;
    logic [7:0] v;
    pl = (idx < 2) ? 0 : 1;
    s  = (pl == 0) ? s1 : s2;
    k  = idx % 2;
    d  = (s / (10**k)) % 10;
    if ((k > 0) && (s < 10**k)) v = 8'h00;
    else v = enc(d);
    if (idx == 2) v = v | 8'h01;
    n = cyc - go_cyc;
    if (BLINK_ON && go_seen && w[pl] && ((((n - 1) / 8) % 2) == 1)) v = 8'h00;
    return ~v;
  endfunction

  // Flush one scan round, then compare every cycle of the next round.
  task automatic check_display(string name, int s1, int s2, logic [1:0] w);
    bit         seen [4];
    int         idx;
    logic [3:0] oh;
    for (int i = 0; i < 4; i++) seen[i] = 1'b0;
    repeat (16) tick();
    for (int c = 0; c < 16; c++) begin
      tick();
      idx = -1;
      for (int i = 0; i < 4; i++) begin
        oh = 4'b0001 << i;
        if (mdsel == ~oh) idx = i;
      end
      if (idx < 0) begin
        check({name, " onehot"}, {28'd0, mdsel}, 32'hFFFF);
      end else begin
        seen[idx] = 1'b1;
        check($sformatf("%s idx%0d", name, idx), {24'd0, mseg}, {24'd0, want_seg(idx, s1, s2, w)});
      end
    end
    for (int i = 0; i < 4; i++) check($sformatf("%s seen%0d", name, i), {31'd0, seen[i]}, 32'd1);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: bench did not finish, got timeout expected finish");
    $fatal(1);
  end

  initial begin
    rst_n = 1'b0; p1 = 1'b0; p2 = 1'b0; clr = 1'b0;
    rst_w = 1'b0; p1_w = 1'b0; p2_w = 1'b0; clr_w = 1'b0;
    use_w = 1'b0;

    // ---------------- vector table ----------------
    for (int i = 1; i <= 9; i++) add(1, 0, 0, i, 0, 2'b00, 0, i == 9);
    add(1, 0, 0, 10, 0, 2'b00, 0, 1);
    for (int i = 1; i <= 10; i++) add(0, 1, 0, 10, i, 2'b00, 0, i == 10);
    add(1, 1, 0, 11, 11, 2'b00, 0, 0);
    add(0, 0, 0, 11, 11, 2'b11, 1, 0);
    add(1, 1, 0, 11, 11, 2'b11, 1, 0);
    add(0, 1, 0, 11, 11, 2'b11, 1, 1);
    add(0, 0, 1, 0, 0, 2'b00, 0, 1);
    add(1, 0, 0, 1, 0, 2'b00, 0, 0);
    add(1, 0, 1, 0, 0, 2'b00, 0, 0);
    for (int i = 1; i <= 11; i++) add(1, 0, 0, i, 0, 2'b00, 0, 0);
    add(0, 0, 0, 11, 0, 2'b01, 1, 0);
    add(0, 1, 1, 0, 0, 2'b00, 0, 0);
    add(0, 0, 0, 0, 0, 2'b00, 0, 1);
    for (int i = 1; i <= 11; i++) add(0, 1, 0, 0, i, 2'b00, 0, 0);
    add(0, 0, 0, 0, 11, 2'b10, 1, 1);

    // ---------------- reset and first scan ----------------
    repeat (3) tick();
    check("rst seg", {24'd0, seg}, 32'hFF);
    check("rst dsel", {28'd0, dsel}, 32'hF);
    check("rst win", {30'd0, win}, 32'd0);
    check("rst go", {31'd0, go}, 32'd0);
    rst_n = 1'b1;
    rst_w = 1'b1;
    tick();
    check("release seg", {24'd0, seg}, 32'hFF);
    check("release dsel", {28'd0, dsel}, 32'hF);
    repeat (3) tick();
    check("pre digit0 dsel", {28'd0, dsel}, 32'hF);
    tick();
    check("digit0 dsel", {28'd0, dsel}, 32'hE);
    check("digit0 seg", {24'd0, seg}, 32'h03);

    // ---------------- table run ----------------
    for (int r = 0; r < tbl.size(); r++) begin
      p1 = tbl[r].pp1; p2 = tbl[r].pp2; clr = tbl[r].clr;
      tick();
      p1 = 1'b0; p2 = 1'b0; clr = 1'b0;
      check($sformatf("vec%0d win", r), {30'd0, win}, {30'd0, tbl[r].win});
      check($sformatf("vec%0d go", r), {31'd0, go}, {31'd0, tbl[r].go});
      if (tbl[r].disp)
        check_display($sformatf("vec%0d disp", r), tbl[r].s1, tbl[r].s2, tbl[r].win);
    end

    // ---------------- game over hold, blink if built in ----------------
    check_display("p2win hold", 0, 11, 2'b10);
    check_display("p2win hold2", 0, 11, 2'b10);
    check("p2win win", {30'd0, win}, 32'd2);

    // ---------------- reset mid-game ----------------
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    check("midrst seg", {24'd0, seg}, 32'hFF);
    check("midrst dsel", {28'd0, dsel}, 32'hF);
    check("midrst win", {30'd0, win}, 32'd0);
    check("midrst go", {31'd0, go}, 32'd0);
    check_display("midrst disp", 0, 0, 2'b00);

    // ---------------- WIN_SCORE=0 wrap-around ----------------
    use_w = 1'b1;
    for (int i = 0; i < 99; i++) begin
      p2_w = 1'b1;
      tick();
    end
    p2_w = 1'b0;
    check_display("wrap 99", 0, 99, 2'b00);
    check("wrap99 go", {31'd0, go_w}, 32'd0);
    p2_w = 1'b1;
    tick();
    p2_w = 1'b0;
    tick();
    check("wrap go", {31'd0, go_w}, 32'd0);
    check("wrap win", {30'd0, win_w}, 32'd0);
    check_display("wrap 00", 0, 0, 2'b00);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
